// File: rtl/sram_mmio_responder.sv
// rtl/sram_mmio_responder.sv - data SRAM responder with byte-enabled RAM and MMIO register page
//
// Purpose: answers single-cycle CPU data SRAM requests. Each accepted request
// returns registered read data one cycle later (read-first on writes) from
// either a 2**RAM_AW x 32 word RAM or a small MMIO page (timer, LED, number
// display, switch input, write counter).
//
// Ports:
//   clk              clock, all state changes on rising edge
//   reset            synchronous, active-high
//   data_sram_en     request valid this cycle
//   data_sram_we     byte write enables, 0 = read
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  registered read data
//   switch_in        board switches, sampled in the request cycle
//   led_out          LED register
//   num_out          display number register
//   timer_out        current timer value
module sram_mmio_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out,
  output logic [31:0] timer_out
);

  localparam int          RAM_DEPTH  = 2 ** RAM_AW;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF020;
  localparam logic [15:0] OFF_NUM    = 16'hF050;
  localparam logic [15:0] OFF_SWITCH = 16'hF060;
  localparam logic [15:0] OFF_WR_CNT = 16'hF070;

  logic [31:0] ram_q [0:RAM_DEPTH-1];

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic              accept;
  logic              is_write;
  logic              is_mmio;
  logic [15:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       mmio_rdata;
  logic [31:0]       timer_wr_val;
  logic [31:0]       num_wr_val;
  logic [1:0]        unused_addr_lsb;

  // Byte-lane merge: lanes with we set take the new data, others keep old.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // Requests presented while reset is high are dropped entirely.
  assign accept          = data_sram_en & ~reset;
  assign is_write        = accept & (data_sram_we != 4'b0000);
  assign is_mmio         = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_off        = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign unused_addr_lsb = data_sram_addr[1:0];
  assign timer_wr_val    = merge_lanes(timer_q, data_sram_wdata, data_sram_we);
  assign num_wr_val      = merge_lanes(num_q, data_sram_wdata, data_sram_we);

  // MMIO read mux sees only registered state, so every read is read-first.
  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OFF_TIMER:  mmio_rdata = timer_q;
      OFF_LED:    mmio_rdata = {16'h0, led_q};
      OFF_NUM:    mmio_rdata = num_q;
      OFF_SWITCH: mmio_rdata = {24'h0, switch_in};
      OFF_WR_CNT: mmio_rdata = wr_cnt_q;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    timer_d  = timer_q + 32'd1;
    led_d    = led_q;
    num_d    = num_q;
    wr_cnt_d = wr_cnt_q;

    if (accept) begin
      rdata_d = is_mmio ? mmio_rdata : ram_q[ram_idx];
    end

    if (is_write) begin
      if (wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
      if (is_mmio) begin
        case (mmio_off)
          // A timer write replaces this cycle's increment.
          OFF_TIMER: timer_d = timer_wr_val;
          OFF_LED: begin
            led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
            led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
          end
          OFF_NUM: num_d = num_wr_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= 32'h0;
      timer_q  <= 32'h0;
      led_q    <= 16'h0;
      num_q    <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      timer_q  <= timer_d;
      led_q    <= led_d;
      num_q    <= num_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // RAM contents survive reset; is_write already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (is_write && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          ram_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;
  assign num_out         = num_q;
  assign timer_out       = timer_q;

endmodule

// File: tb/tb_sram_mmio_responder.sv
// tb/tb_sram_mmio_responder.sv - self-checking bench for sram_mmio_responder
module tb_sram_mmio_responder;

  localparam int RAM_AW = 12;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;
  logic [31:0] timer_out;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_timer;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_wrcnt;
  logic [31:0] m_rdata;
  logic        m_rd_known;

  sram_mmio_responder #(.RAM_AW(RAM_AW), .MMIO_BASE(32'hBFAF_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out),
    .timer_out       (timer_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Apply one clock of the specification's rules to the model.
  task automatic model_cycle(input logic rst, input logic en, input logic [3:0] we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [7:0] sw);
    logic        mmio;
    logic [15:0] off;
    int          idx;
    logic [31:0] next_timer;
    logic [31:0] tmp;
    if (rst) begin
      m_rdata = 0; m_rd_known = 1; m_timer = 0; m_led = 0; m_num = 0; m_wrcnt = 0;
      return;
    end
    next_timer = m_timer + 1;
    if (en) begin
      mmio = (addr[31:16] == 16'hBFAF);
      off  = addr[15:0];
      idx  = int'(addr[RAM_AW+1:2]);
      if (mmio) begin
        m_rd_known = 1;
        if (off == 16'hE000)      m_rdata = m_timer;
        else if (off == 16'hF020) m_rdata = {16'h0, m_led};
        else if (off == 16'hF050) m_rdata = m_num;
        else if (off == 16'hF060) m_rdata = {24'h0, sw};
        else if (off == 16'hF070) m_rdata = m_wrcnt;
        else                      m_rdata = 0;
      end else if (m_ram.exists(idx)) begin
        m_rd_known = 1;
        m_rdata = m_ram[idx];
      end else begin
        m_rd_known = 0;
      end
      if (we != 0) begin
        if (m_wrcnt != 32'hFFFF_FFFF) m_wrcnt = m_wrcnt + 1;
        if (mmio) begin
          if (off == 16'hE000) next_timer = bytes_merge(m_timer, wd, we);
          else if (off == 16'hF020) begin
            tmp = bytes_merge({16'h0, m_led}, wd, we);
            m_led = tmp[15:0];
          end else if (off == 16'hF050) m_num = bytes_merge(m_num, wd, we);
        end else if (m_ram.exists(idx)) begin
          m_ram[idx] = bytes_merge(m_ram[idx], wd, we);
        end else if (we == 4'hF) begin
          m_ram[idx] = wd;
        end
      end
    end
    m_timer = next_timer;
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] sw);
    @(negedge clk);
    reset = rst; data_sram_en = en; data_sram_we = we;
    data_sram_addr = addr; data_sram_wdata = wd; switch_in = sw;
    @(posedge clk);
    model_cycle(rst, en, we, addr, wd, sw);
    #1;
    if (m_rd_known) chk("rdata", data_sram_rdata, m_rdata);
    chk("led_out", {16'h0, led_out}, {16'h0, m_led});
    chk("num_out", num_out, m_num);
    chk("timer_out", timer_out, m_timer);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
  endtask

  logic [31:0] a;
  logic [31:0] wd;
  logic [3:0]  we;
  logic [15:0] offs [7];

  initial begin
    checks = 0; failures = 0;
    m_rd_known = 0;
    reset = 1; data_sram_en = 0; data_sram_we = 0;
    data_sram_addr = 0; data_sram_wdata = 0; switch_in = 0;

    // Reset held 3 cycles; then TIMER read at the 10th cycle after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h0);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_timer", timer_out, 32'h0);
    for (int i = 0; i < 9; i++) idle();
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, 8'h0);
    chk("timer_read_9", data_sram_rdata, 32'd9);

    // Basic RAM write/read and write counter.
    step(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 8'h0);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 8'h0);
    chk("ram_rd_10", data_sram_rdata, 32'h1234_5678);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F070, 32'h0, 8'h0);
    chk("wrcnt_1", data_sram_rdata, 32'd1);

    // Byte-enabled write and aliasing.
    step(1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 8'h0);
    step(1'b0, 1'b1, 4'b0101, 32'h0000_0020, 32'h1122_3344, 8'h0);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0020, 32'h0, 8'h0);
    chk("ram_bytemask", data_sram_rdata, 32'hAA22_CC44);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0020 + (32'h1 << (RAM_AW + 2)), 32'h0, 8'h0);
    chk("ram_alias", data_sram_rdata, 32'hAA22_CC44);

    // Timer write and wrap.
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, 8'h0);
    chk("timer_set", timer_out, 32'hFFFF_FFFE);
    idle();
    chk("timer_max", timer_out, 32'hFFFF_FFFF);
    idle();
    chk("timer_wrap", timer_out, 32'h0);

    // LED, SWITCH (read-only, write still counted).
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_F020, 32'hDEAD_BEEF, 8'h0);
    chk("led_out_beef", {16'h0, led_out}, 32'h0000_BEEF);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F020, 32'h0, 8'h0);
    chk("led_read", data_sram_rdata, 32'h0000_BEEF);
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_F060, 32'hFFFF_FFFF, 8'h00);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F060, 32'h0, 8'h5A);
    chk("switch_read", data_sram_rdata, 32'h0000_005A);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F070, 32'h0, 8'h0);
    chk("wrcnt_6", data_sram_rdata, 32'd6);

    // Read-first on back-to-back writes; unmapped MMIO offset.
    step(1'b0, 1'b1, 4'hF, 32'h0000_0030, 32'h1, 8'h0);
    step(1'b0, 1'b1, 4'hF, 32'h0000_0030, 32'h2, 8'h0);
    chk("read_first", data_sram_rdata, 32'h1);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F100, 32'h0, 8'h0);
    chk("unmapped_rd", data_sram_rdata, 32'h0);

    // Reset while a NUM read is outstanding.
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_F050, 32'h0000_0077, 8'h0);
    step(1'b0, 1'b1, 4'h0, 32'hBFAF_F050, 32'h0, 8'h0);
    step(1'b1, 1'b1, 4'h0, 32'hBFAF_F050, 32'h0, 8'h0);
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_num", num_out, 32'h0);
    idle();
    chk("rst_no_stale", data_sram_rdata, 32'h0);

    // Prefill a small RAM window, then randomized traffic.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom, 8'h0);
    offs[0] = 16'hE000; offs[1] = 16'hF020; offs[2] = 16'hF050; offs[3] = 16'hF060;
    offs[4] = 16'hF070; offs[5] = 16'hF100; offs[6] = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      wd = $urandom;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom;
        a[RAM_AW+1:2] = RAM_AW'($urandom_range(0, 7));
        if (a[31:16] == 16'hBFAF) a[16] = ~a[16];
      end else begin
        a = {16'hBFAF, offs[$urandom_range(0, 6)]};
        if (a[15:0] == 16'h0000) a[15:0] = 16'($urandom);
      end
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), we, a, wd,
           8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
